// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with a three-state fetch FSM
//            (BOOT / REQ / HOLD), branch redirect, stall hold and a sticky
//            address-wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int              WIDTH    = 64,
  parameter int              STEP     = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             iack_i,
  output logic             ireq_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic             valid_o,
  output logic             wrap_o
);

  // Increment as a WIDTH-bit value; the alignment mask clears the low
  // log2(STEP) bits of a redirect target so fetches stay STEP-aligned.
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 1));

  // Reject non-power-of-two or zero increments at elaboration.
  if ((STEP < 1) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
    $error("pc_sequencer: STEP must be a power of two >= 1");
  end

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;
  logic             wrap_q;
  logic             ireq_q;
  logic [WIDTH:0]   sum_d;

  // One-bit-wider adder so the carry out of WIDTH is visible for Wrap.
  assign sum_d     = {1'b0, pc_q} + {1'b0, STEP_W};
  assign pc_next_o = sum_d[WIDTH-1:0];

  // Fetch FSM: priority is reset, then redirect, then stall, then accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ireq_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          // One idle cycle after reset before the first request.
          state_q <= S_REQ;
          ireq_q  <= 1'b1;
        end
        S_REQ, S_HOLD: begin
          if (br_taken_i) begin
            // Redirect squashes any fetch accepted this cycle; Wrap untouched.
            pc_q    <= br_target_i & ALIGN_MASK;
            state_q <= stall_i ? S_HOLD : S_REQ;
            ireq_q  <= ~stall_i;
          end else if (stall_i) begin
            state_q <= S_HOLD;
            ireq_q  <= 1'b0;
          end else if (state_q == S_HOLD) begin
            // Stall released: resume requesting; IAck is meaningless here.
            state_q <= S_REQ;
            ireq_q  <= 1'b1;
          end else if (iack_i) begin
            pc_q    <= pc_next_o;
            valid_q <= 1'b1;
            if (sum_d[WIDTH]) begin
              wrap_q <= 1'b1;
            end
            ireq_q  <= 1'b1;
          end else begin
            ireq_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_BOOT;
          ireq_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ireq_o  = ireq_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed table-driven bench for pc_sequencer (64-bit default
//            instance) plus a hand-written wrap sequence on an 8-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk;
  logic        rst, stall, br, iack;
  logic [63:0] tgt;
  logic        ireq;
  logic [63:0] pc, pcn;
  logic        valid, wrap;

  logic        rst8, stall8, br8, iack8;
  logic [7:0]  tgt8;
  logic        ireq8;
  logic [7:0]  pc8, pcn8;
  logic        valid8, wrap8;

  int tests  = 0;
  int failed = 0;

  pc_sequencer u_dut (
    .clk_i(clk), .reset_i(rst), .stall_i(stall), .br_taken_i(br),
    .br_target_i(tgt), .iack_i(iack), .ireq_o(ireq), .pc_o(pc),
    .pc_next_o(pcn), .valid_o(valid), .wrap_o(wrap)
  );

  pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_PC(8'h00)) u_dut8 (
    .clk_i(clk), .reset_i(rst8), .stall_i(stall8), .br_taken_i(br8),
    .br_target_i(tgt8), .iack_i(iack8), .ireq_o(ireq8), .pc_o(pc8),
    .pc_next_o(pcn8), .valid_o(valid8), .wrap_o(wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic        iack;
    logic [63:0] e_pc;
    logic        e_valid;
    logic        e_ireq;
    logic        e_wrap;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic s, logic b, logic [63:0] t, logic a,
                              logic [63:0] p, logic v, logic q, logic w);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.iack = a;
    x.e_pc = p; x.e_valid = v; x.e_ireq = q; x.e_wrap = w;
    return x;
  endfunction

  task automatic step8(input logic r, input logic s, input logic b, input logic [7:0] t,
                       input logic a);
    @(negedge clk);
    rst8 = r; stall8 = s; br8 = b; tgt8 = t; iack8 = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; iack = 1'b0;
    rst8 = 1'b1; stall8 = 1'b0; br8 = 1'b0; tgt8 = '0; iack8 = 1'b0;

    //            rst stl br  target                 ack  exp_pc                 v  ireq wrap
    vecs[0]  = mk(1, 0, 0, 64'h0,                  0, 64'h0,                  0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 64'h0,                  1, 64'h0,                  0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 64'h0,                  1, 64'h4,                  1, 1, 0);
    vecs[3]  = mk(0, 0, 0, 64'h0,                  1, 64'h8,                  1, 1, 0);
    vecs[4]  = mk(0, 0, 0, 64'h0,                  1, 64'hC,                  1, 1, 0);
    vecs[5]  = mk(0, 0, 0, 64'h0,                  0, 64'hC,                  0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 64'h0,                  1, 64'h10,                 1, 1, 0);
    vecs[7]  = mk(0, 1, 0, 64'h0,                  1, 64'h10,                 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 64'h0,                  1, 64'h10,                 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 64'h0,                  1, 64'h10,                 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 64'h0,                  1, 64'h14,                 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 64'h0,                  1, 64'h18,                 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 64'h0,                  1, 64'h1C,                 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 64'h0,                  1, 64'h20,                 1, 1, 0);
    vecs[14] = mk(0, 0, 1, 64'h103,                1, 64'h100,                0, 1, 0);
    vecs[15] = mk(0, 1, 1, 64'h207,                0, 64'h204,                0, 0, 0);
    vecs[16] = mk(0, 1, 1, 64'h333,                1, 64'h330,                0, 0, 0);
    vecs[17] = mk(0, 1, 0, 64'h0,                  1, 64'h330,                0, 0, 0);
    vecs[18] = mk(1, 1, 1, 64'h444,                1, 64'h0,                  0, 0, 0);
    vecs[19] = mk(0, 0, 0, 64'h0,                  1, 64'h0,                  0, 1, 0);
    vecs[20] = mk(0, 0, 0, 64'h0,                  1, 64'h4,                  1, 1, 0);
    vecs[21] = mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 64'h0,                  1, 64'h0,                  1, 1, 1);
    vecs[23] = mk(0, 0, 1, 64'h50,                 1, 64'h50,                 0, 1, 1);
    vecs[24] = mk(1, 0, 0, 64'h0,                  1, 64'h0,                  0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; br = vecs[i].br;
      tgt = vecs[i].tgt; iack = vecs[i].iack;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i),    pc,           vecs[i].e_pc);
      chk($sformatf("v%0d pcnext", i), pcn,         vecs[i].e_pc + 64'd4);
      chk($sformatf("v%0d valid", i), 64'(valid),   64'(vecs[i].e_valid));
      chk($sformatf("v%0d ireq", i),  64'(ireq),    64'(vecs[i].e_ireq));
      chk($sformatf("v%0d wrap", i),  64'(wrap),    64'(vecs[i].e_wrap));
    end

    // 8-bit instance: carry out of the top PC bit sets a sticky Wrap.
    step8(1, 0, 0, 8'h00, 0);
    chk("w8 reset pc", 64'(pc8), 64'h0);
    chk("w8 reset ireq", 64'(ireq8), 64'h0);
    step8(0, 0, 0, 8'h00, 0);
    chk("w8 boot->req ireq", 64'(ireq8), 64'h1);
    step8(0, 0, 1, 8'hFE, 0);
    chk("w8 redirect pc", 64'(pc8), 64'hFC);
    chk("w8 pcnext at FC", 64'(pcn8), 64'h00);
    chk("w8 redirect wrap", 64'(wrap8), 64'h0);
    step8(0, 0, 0, 8'h00, 1);
    chk("w8 wrapped pc", 64'(pc8), 64'h00);
    chk("w8 wrap set", 64'(wrap8), 64'h1);
    chk("w8 wrap valid", 64'(valid8), 64'h1);
    step8(0, 0, 1, 8'h13, 1);
    chk("w8 branch pc", 64'(pc8), 64'h10);
    chk("w8 wrap sticky br", 64'(wrap8), 64'h1);
    chk("w8 branch valid", 64'(valid8), 64'h0);
    step8(0, 0, 0, 8'h00, 1);
    chk("w8 advance pc", 64'(pc8), 64'h14);
    chk("w8 wrap sticky adv", 64'(wrap8), 64'h1);
    step8(1, 0, 1, 8'h80, 1);
    chk("w8 reset clears wrap", 64'(wrap8), 64'h0);
    chk("w8 reset pc again", 64'(pc8), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
